// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared state encodings and constants for the instruction-fetch stage
package inst_fetch_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DRAIN = 2'd3} fetch_state_t;
   localparam int DEF_ADDR_W = 15;
   localparam logic [31:0] NOP = 32'h0;
endpackage

// File: rtl/inst_fetch_addr_check.sv
// fetch_addr_check: flags misaligned or out-of-range byte PCs and derives the memory word address
module fetch_addr_check #(
   parameter int ADDR_W = 15
) (
   input  logic [31:0]       pc,
   output logic              fault,
   output logic [ADDR_W-1:0] mem_addr
);
   assign fault    = (pc[1:0] != 2'b00) || (pc[31:ADDR_W+2] != '0);
   assign mem_addr = pc[ADDR_W+1:2];
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: fetches one instruction word per enable over a req/valid memory port, with flush and fault handling
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              enable,
   input  logic [31:0]       pc,
   input  logic              flush,
   output logic              done,
   output logic [31:0]       pc_out,
   output logic [31:0]       command,
   output logic              fault,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_req,
   input  logic              mem_valid,
   input  logic [31:0]       mem_data
);
   fetch_state_t      state;
   logic [31:0]       pc_lat;
   logic              bad_pc;
   logic [ADDR_W-1:0] word_addr;

   fetch_addr_check #(.ADDR_W(ADDR_W)) u_check (
      .pc       (pc),
      .fault    (bad_pc),
      .mem_addr (word_addr)
   );

   // fetch FSM; done and mem_req are single-cycle pulses, other outputs hold between fetches
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         pc_lat   <= '0;
         done     <= 1'b0;
         pc_out   <= '0;
         command  <= '0;
         fault    <= 1'b0;
         mem_addr <= '0;
         mem_req  <= 1'b0;
      end else begin
         done    <= 1'b0;
         mem_req <= 1'b0;
         case (state)
            IDLE: if (enable && !flush) begin
               if (bad_pc) begin
                  command <= NOP;
                  fault   <= 1'b1;
                  pc_out  <= pc;
                  done    <= 1'b1;
               end else begin
                  pc_lat   <= pc;
                  mem_addr <= word_addr;
                  mem_req  <= 1'b1;
                  state    <= REQ;
               end
            end
            REQ: state <= flush ? DRAIN : WAIT;
            WAIT: if (mem_valid) begin
               state <= IDLE;
               if (!flush) begin
                  command <= mem_data;
                  pc_out  <= pc_lat;
                  fault   <= 1'b0;
                  done    <= 1'b1;
               end
            end else if (flush) begin
               state <= DRAIN;
            end
            DRAIN: if (mem_valid) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized and directed checks of inst_fetch against a transaction-level model
module tb_inst_fetch;
   import inst_fetch_pkg::*;
   localparam int AW = DEF_ADDR_W;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          enable = 1'b0;
   logic [31:0]   pc = '0;
   logic          flush = 1'b0;
   logic          done;
   logic [31:0]   pc_out;
   logic [31:0]   command;
   logic          fault;
   logic [AW-1:0] mem_addr;
   logic          mem_req;
   logic          mem_valid = 1'b0;
   logic [31:0]   mem_data = '0;

   int          checks = 0;
   int          errors = 0;
   int          lat = 1;
   int          cd = 0;
   logic [31:0] rdata = '0;
   logic [31:0] want_pc = '0;
   logic [31:0] want_cmd = '0;
   logic        want_fault = 1'b0;

   inst_fetch #(.ADDR_W(AW)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .enable    (enable),
      .pc        (pc),
      .flush     (flush),
      .done      (done),
      .pc_out    (pc_out),
      .command   (command),
      .fault     (fault),
      .mem_addr  (mem_addr),
      .mem_req   (mem_req),
      .mem_valid (mem_valid),
      .mem_data  (mem_data)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, want);
      end
   endtask

   // one clock; memory answers each request exactly lat cycles later, garbage data otherwise
   task automatic tick();
      @(posedge clk);
      #1;
      mem_valid = 1'b0;
      mem_data  = $urandom;
      if (cd > 0) begin
         cd--;
         if (cd == 0) begin
            mem_valid = 1'b1;
            mem_data  = rdata;
         end
      end
      if (mem_req) cd = lat;
   endtask

   // f: cycle flush is raised (-1 none, 0 with enable); e: cycle a stray enable (pc=0x40) is raised
   task automatic run_fetch(input logic [31:0] p, input int l, input logic [31:0] d, input int f, input int e);
      int reqs, dones, done_c;
      logic [31:0] req_addr;
      bit bad, started, flushed, want_req, want_done;
      bad       = (p % 4 != 0) || (p >= (32'd4 << AW));
      started   = (f != 0);
      flushed   = !bad && f >= 1 && f <= l + 1;
      want_req  = started && !bad;
      want_done = started && (bad || !flushed);
      lat = l;
      rdata = d;
      pc = p;
      enable = 1'b1;
      flush = (f == 0);
      tick();
      reqs = 0;
      dones = 0;
      done_c = 0;
      req_addr = '0;
      for (int c = 1; c <= l + 4; c++) begin
         if (mem_req) begin
            reqs++;
            req_addr = 32'(mem_addr);
         end
         if (done) begin
            dones++;
            done_c = c;
         end
         enable = (c == e);
         pc = (c == e) ? 32'h40 : p;
         flush = (c == f);
         tick();
      end
      enable = 1'b0;
      flush = 1'b0;
      if (want_done) begin
         want_pc = p;
         want_cmd = bad ? NOP : d;
         want_fault = bad;
      end
      chk("req_count", reqs, want_req ? 1 : 0);
      if (want_req) chk("req_addr", req_addr, p / 4);
      chk("done_count", dones, want_done ? 1 : 0);
      if (want_done) chk("done_cycle", done_c, bad ? 1 : l + 2);
      chk("pc_out", pc_out, want_pc);
      chk("command", command, want_cmd);
      chk("fault", fault, want_fault);
   endtask

   initial begin
      int dn;
      tick();
      tick();
      chk("rst_done", done, 0);
      chk("rst_pc_out", pc_out, 0);
      chk("rst_command", command, 0);
      chk("rst_fault", fault, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      rstn = 1'b1;
      tick();
      run_fetch(32'h10, 1, 32'h20210005, -1, -1);
      run_fetch(32'h6, 1, 32'h11111111, -1, -1);
      run_fetch(32'h20000, 1, 32'h22222222, -1, -1);
      run_fetch(32'h80, 4, 32'h33333333, 2, -1);
      run_fetch(32'h84, 2, 32'h44444444, -1, -1);
      run_fetch(32'h90, 2, 32'h55555555, 3, -1);
      run_fetch(32'h94, 1, 32'h66666666, -1, -1);
      run_fetch(32'h200, 3, 32'h77777777, -1, 3);
      run_fetch(32'h300, 2, 32'h88888888, 0, -1);
      run_fetch(32'h1fffc, 1, 32'h99999999, -1, -1);
      for (int i = 0; i < 60; i++) begin
         logic [31:0] p;
         int l, f, e;
         case ($urandom_range(0, 3))
            0, 1: p = 32'($urandom_range(0, (1 << AW) - 1)) << 2;
            2: p = ($urandom & 32'h1fffc) | 32'($urandom_range(1, 3));
            default: p = ($urandom | 32'h20000) & ~32'h3;
         endcase
         l = $urandom_range(1, 5);
         f = ($urandom_range(0, 9) < 6) ? -1 : $urandom_range(0, l + 2);
         e = (f == 0 || p % 4 != 0 || p >= (32'd4 << AW) || $urandom_range(0, 9) < 7) ? -1 : $urandom_range(2, l + 1);
         run_fetch(p, l, $urandom, f, e);
      end
      lat = 1;
      rdata = 32'hAAAA0001;
      pc = 32'h100;
      enable = 1'b1;
      tick();
      enable = 1'b0;
      chk("b2b_req1", mem_req, 1);
      tick();
      tick();
      chk("b2b_done1", done, 1);
      chk("b2b_cmd1", command, 32'hAAAA0001);
      pc = 32'h104;
      enable = 1'b1;
      rdata = 32'hBBBB0002;
      tick();
      enable = 1'b0;
      chk("b2b_req2", mem_req, 1);
      chk("b2b_addr2", mem_addr, 32'h41);
      chk("b2b_nodone", done, 0);
      tick();
      tick();
      chk("b2b_done2", done, 1);
      chk("b2b_cmd2", command, 32'hBBBB0002);
      chk("b2b_pc2", pc_out, 32'h104);
      tick();
      lat = 6;
      rdata = 32'hCCCC0003;
      pc = 32'h500;
      enable = 1'b1;
      tick();
      enable = 1'b0;
      tick();
      tick();
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_done", done, 0);
      chk("arst_pc_out", pc_out, 0);
      chk("arst_command", command, 0);
      chk("arst_fault", fault, 0);
      chk("arst_mem_req", mem_req, 0);
      chk("arst_mem_addr", mem_addr, 0);
      tick();
      tick();
      rstn = 1'b1;
      dn = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         dn += int'(done);
      end
      chk("stray_valid_done", dn, 0);
      want_pc = '0;
      want_cmd = '0;
      want_fault = 1'b0;
      run_fetch(32'h600, 2, 32'hDDDD0004, -1, -1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage sitting directly upstream of the decode stage. On an `enable` pulse it validates the supplied program counter, reads one 32-bit instruction word from instruction memory over a request/valid interface, and presents `pc_out`/`command` with a one-cycle `done` pulse that the controller forwards as decode's `enable`. It supports flushing an in-flight fetch on branch/jump redirect and flags illegal fetch addresses.

## Interface
- `ADDR_W`, 15: instruction-memory word-address width; legal byte PCs are `0 .. 2^(ADDR_W+2)-4`.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  start pulse; sampled only in IDLE.
- `pc`  in  32  byte address of the instruction to fetch; sampled with `enable`.
- `flush`  in  1  abort the current fetch; its result is discarded.
- `done`  out  1  one-cycle pulse; `pc_out`/`command`/`fault` are valid from this cycle until the next `done`.
- `pc_out`  out  32  PC of the fetched instruction.
- `command`  out  32  fetched instruction word.
- `fault`  out  1  fetch address was misaligned or out of range.
- `mem_addr`  out  ADDR_W  word address, `pc[ADDR_W+1:2]`.
- `mem_req`  out  1  one-cycle read request.
- `mem_valid`  in  1  read data valid; exactly one per request, any latency ≥1.
- `mem_data`  in  32  read data, sampled when `mem_valid`=1.

## Operation
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE + `enable`: latch `pc`. If `pc[1:0]`≠0 or `pc[31:ADDR_W+2]`≠0, issue no request, set `command`=0 (NOP), `fault`=1, `pc_out`=pc, and pulse `done` next cycle; stay IDLE. Otherwise drive `mem_addr` and go to REQ.
- REQ: `mem_req`=1 for exactly this cycle → WAIT.
- WAIT + `mem_valid`: capture `mem_data` into `command`, `pc_out`=latched PC, `fault`=0, `done`=1 next cycle → IDLE.
- `flush` in REQ or WAIT (without `mem_valid` that cycle) → DRAIN; the request is still issued if in REQ. DRAIN + `mem_valid`: discard the data → IDLE, no `done`.
- `flush` in the same cycle as `mem_valid` in WAIT: data discarded, → IDLE, no `done`.
- `flush` in IDLE: no effect. `flush` together with `enable` in IDLE: `enable` ignored.
- `enable` outside IDLE: ignored (no queueing).
- `mem_valid` in IDLE or REQ: ignored.
- `done` never asserts for a flushed fetch. Outputs other than `done` hold their values between fetches.

## Timing
- Reset (async): state IDLE; `done`=0, `pc_out`=0, `command`=0, `fault`=0, `mem_req`=0, `mem_addr`=0. Reset mid-fetch abandons it; a late `mem_valid` after reset is ignored.
- Legal fetch, memory latency L (`mem_valid` L cycles after `mem_req`): `enable` at cycle 0 → `mem_req` cycle 1 → `mem_valid` cycle 1+L → `done` cycle 2+L. With BRAM (L=1), `done` arrives at cycle 3.
- Faulting fetch: `enable` at cycle 0 → `done` at cycle 1, with no `mem_req`.
- Back-to-back: `enable` may be asserted in the same cycle as `done` (state is already IDLE), giving a throughput of one fetch per 3+L-1 cycles.
- `mem_addr` is stable from REQ until the return to IDLE.

## Structure
- A shared header holds the state encodings (2-bit), the `NOP` constant (32'h0), and the `ADDR_W` default, so the controller and testbench use the same values.
- One natural sub-module is `fetch_addr_check`: combinational checks for `pc` alignment and range, producing `fault` and `mem_addr`. Everything else, including the FSM and output registers, stays in `inst_fetch`.

## Test plan
- Reset then `enable` with pc=0x00000010, BRAM L=1, mem_data=0x20210005 → `mem_req` at cycle 1 with `mem_addr`=4; `done` at cycle 3 with `command`=0x20210005, `pc_out`=0x10, `fault`=0.
- pc=0x00000006 → no `mem_req`; `done` at cycle 1 with `fault`=1, `command`=0. Also pc=0x00020000 (ADDR_W=15) → same fault response.
- L=4, `flush` at cycle 2 → state DRAIN; `mem_valid` at cycle 5 is discarded and `done` never pulses. A new `enable` at cycle 6 then fetches normally.
- `flush` and `mem_valid` in the same cycle → no `done`, state IDLE next cycle.
- `enable` repeated during WAIT (pc=0x40) is ignored; `pc_out` still equals the first pc. `enable` asserted in the `done` cycle starts the next fetch immediately.
- `rstn` low during WAIT → all outputs go to 0 asynchronously; a stray `mem_valid` after release produces no `done`.
